// File: rtl/seq_div_8by4.sv
// seq_div_8by4: sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional macro SEQ_DIV_FASTPATH_EN: one-cycle result when dividend < divisor.  Rev 1.0
`default_nettype none

module seq_div_8by4 #(
  parameter int DW_N = 8,
  parameter int DW_D = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW_N-1:0] dividend,
  input  logic [DW_D-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [DW_N-1:0] quotient,
  output logic [DW_D-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = (DW_N > 1) ? $clog2(DW_N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ZERO = 2'd2,
    FAST = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW_D-1:0]   p_q, p_d;
  logic [DW_N-1:0]   dvd_q, dvd_d;
  logic [DW_D-1:0]   dvs_q, dvs_d;
  logic [DW_N-1:0]   quo_q, quo_d;
  logic [DW_D-1:0]   rem_q, rem_d;

  // The partial remainder is always < divisor, so DW_D bits hold it between steps.
  logic [DW_D:0]     p_shift;
  logic [DW_D:0]     p_step;
  logic              q_bit;
  logic [DW_N-1:0]   dvd_step;

  always_comb begin
    p_shift  = {p_q, dvd_q[DW_N-1]};
    q_bit    = (p_shift >= {1'b0, dvs_q});
    p_step   = q_bit ? (p_shift - {1'b0, dvs_q}) : p_shift;
    dvd_step = {dvd_q[DW_N-2:0], q_bit};

    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          p_d    = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (divisor == '0) begin
            state_d = ZERO;
`ifdef SEQ_DIV_FASTPATH_EN
          end else if (dividend < DW_N'(divisor)) begin
            state_d = FAST;
`endif
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d   = p_step[DW_D-1:0];
        dvd_d = dvd_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW_N - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = dvd_step;
          rem_d   = p_step[DW_D-1:0];
          dbz_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ZERO: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        quo_d   = '1;
        rem_d   = '0;
        dbz_d   = 1'b1;
      end
      FAST: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        quo_d   = '0;
        rem_d   = dvd_q[DW_D-1:0];
        dbz_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: doc/seq_div_8by4.md
Name: seq_div_8by4

Overview:
- Sequential restoring divider, the inverse of the 4x4 unsigned multiplier in the arithmetic library.
- Takes an 8-bit unsigned dividend and a 4-bit unsigned divisor; produces an 8-bit quotient and a 4-bit remainder.
- Computes one quotient bit per clock under a start/busy/done handshake.
- Lets benches round-trip multiplier results: product / operand -> other operand, remainder 0.

Parameters:
- DW_N, 8, dividend and quotient width (>= DW_D).
- DW_D, 4, divisor and remainder width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- dividend  input  DW_N  numerator; captured on the accepted start edge.
- divisor  input  DW_D  denominator; captured on the accepted start edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; quotient/remainder/div_by_zero valid.
- quotient  output  DW_N  result quotient; held until next completion.
- remainder  output  DW_D  result remainder; held until next completion.
- div_by_zero  output  1  set with done when the captured divisor = 0.

Behaviour:
- Reset (async assert, any state): state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal count and partial remainder=0. Any in-flight operation is dropped and produces no done.
- States:
  - IDLE: busy=0. start=1 at edge E0 captures operands; goes to CALC, or ZERO if divisor=0.
  - CALC: busy=1. Iteration counter 0..DW_N-1.
  - ZERO: busy=1 for one cycle.
- CALC step per edge:
  - Partial remainder P (DW_D+1 bits) = {P[DW_D-1:0], next dividend MSB}.
  - If P >= divisor: P -= divisor, quotient bit = 1; else quotient bit = 0.
  - Dividend register shifts left; quotient bits enter at LSB.
- Completion: the step at edge E(DW_N) is the last.
  - quotient/remainder registers load at that edge; state -> IDLE, busy=0, done=1.
  - done drops at the next edge.
  - Latency: start edge to done high = DW_N edges (8 by default).
- ZERO: at edge E1, quotient = all ones, remainder = 0, div_by_zero=1, done=1; state -> IDLE.
- div_by_zero updates only at completion; cleared by the next normal completion.
- Invariant on every normal completion: quotient*divisor + remainder == dividend, remainder < divisor.
- start while busy=1: ignored; captured operands unchanged.
- start in the done cycle: accepted (state is IDLE). Back-to-back operations are legal, one per DW_N+1 cycles minimum.
- Operand inputs are don't-care except on accepting edges.
- Outputs keep the last result between operations; they never show intermediate values.

Optional Feature:
- Macro SEQ_DIV_FASTPATH_EN.
- Defined: at the accepting edge, if divisor != 0 and dividend < divisor, go to a one-cycle FAST state. At E1: quotient=0, remainder=dividend[DW_D-1:0], done=1, busy=0.
- Not defined: such operands run the full DW_N-cycle CALC path with an identical result.
- Divide-by-zero handling is identical with and without the macro.

Test Plan:
- Reset then idle: all outputs 0, busy=0. start with 10/2 -> busy high for 8 cycles, done at E8, quotient=5, remainder=0, div_by_zero=0.
- Sequence 6/3, 35/7, 200/7, 255/15 back-to-back, each start issued in the previous done cycle -> 2r0, 5r0, 28r4, 17r0; each done exactly 8 edges after its start.
- 9/0 -> done at E1, quotient=255, remainder=0, div_by_zero=1. Next 15/4 -> 3r3 with div_by_zero=0.
- Start 100/3, then pulse start with 50/5 at E3 (busy=1) -> ignored; result 33r1 at E8.
- Start 200/7, assert rst at E4 -> busy=0, done never pulses, outputs 0. After release, 16/4 -> 4r0.
- 3/7 -> quotient=0, remainder=3; done at E1 with SEQ_DIV_FASTPATH_EN defined, at E8 without. Exhaustive random sweep checks the invariant in both builds.
